param_stream_sequencer: RTL and testbench

PARAM_STREAM_SEQUENCER -- requirements
Module: param_stream_sequencer

---
 rtl/param_stream_sequencer.sv | 110 +++++++++++
 tb/tb_param_stream_sequencer.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_stream_sequencer.sv
// Streams a small parameter table out of an AXI-Stream style master port,
// one pass per start request, with a single-cycle done pulse at the end.
module param_stream_sequencer #(
  parameter int N_CHANNELS = 2,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 8,
  parameter int BASE_DEST  = 0,
  parameter logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] INITIAL_VALUES =
    {DATA_WIDTH'(32), DATA_WIDTH'(5)}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  wr_en,
  input  logic [((N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [DEST_WIDTH-1:0] m_tdest,
  output logic                  m_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready
);

  // state  | meaning
  // IDLE   | waiting for start
  // STREAM | entry idx_q presented on the stream port
  // DONE   | one-cycle pass-complete pulse
  localparam int AW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N_CHANNELS - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         idx_q, idx_d, idx_nxt;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [DEST_WIDTH-1:0] tdest_q, tdest_d;
  logic                  tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0] table_q [N_CHANNELS];
  logic [DATA_WIDTH-1:0] table_d [N_CHANNELS];

  always_comb begin
    table_d = table_q;
    state_d = state_q;
    idx_d   = idx_q;
    tdata_d = tdata_q;
    tdest_d = tdest_q;
    tlast_d = tlast_q;
    idx_nxt = idx_q + 1'b1;

    for (int i = 0; i < N_CHANNELS; i++) begin
      if (wr_en && (wr_addr == AW'(i))) table_d[i] = wr_data;
    end

    // loads read table_q, so a same-edge write to the loaded index is not seen
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STREAM;
          idx_d   = '0;
          tdata_d = table_q[0];
          tdest_d = DEST_WIDTH'(BASE_DEST);
          tlast_d = (N_CHANNELS == 1);
        end
      end
      S_STREAM: begin
        if (m_tready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            tlast_d = 1'b0;
          end else begin
            idx_d   = idx_nxt;
            tdata_d = table_q[idx_nxt];
            tdest_d = DEST_WIDTH'(BASE_DEST) + DEST_WIDTH'(idx_nxt);
            tlast_d = (idx_nxt == LAST_IDX);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      tdata_q <= '0;
      tdest_q <= DEST_WIDTH'(BASE_DEST);
      tlast_q <= 1'b0;
      for (int i = 0; i < N_CHANNELS; i++) table_q[i] <= INITIAL_VALUES[i];
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tdata_q <= tdata_d;
      tdest_q <= tdest_d;
      tlast_q <= tlast_d;
      table_q <= table_d;
    end
  end

  assign busy     = (state_q == S_STREAM);
  assign m_tvalid = (state_q == S_STREAM);
  assign done     = (state_q == S_DONE);
  assign m_tdata  = tdata_q;
  assign m_tdest  = tdest_q;
  assign m_tlast  = tlast_q;

endmodule

// File: tb/tb_param_stream_sequencer.sv
// Bench for param_stream_sequencer: default two-entry instance checked through
// an expected-word scoreboard, plus a single-entry instance with BASE_DEST=255.
module tb_param_stream_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic        reset = 1'b0, start = 1'b0, wr_en = 1'b0, m_tready = 1'b0;
  logic        wr_addr = 1'b0;
  logic [31:0] wr_data = '0;
  logic        busy, done, m_tlast, m_tvalid;
  logic [31:0] m_tdata;
  logic [7:0]  m_tdest;

  // single-entry instance
  logic        s_reset = 1'b0, s_start = 1'b0, s_wr_en = 1'b0, s_tready = 1'b0;
  logic        s_wr_addr = 1'b0;
  logic [31:0] s_wr_data = '0;
  logic        s_busy, s_done, s_tlast, s_tvalid;
  logic [31:0] s_tdata;
  logic [7:0]  s_tdest;

  param_stream_sequencer u0 (
    .clock(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .m_tdata(m_tdata), .m_tdest(m_tdest), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  param_stream_sequencer #(
    .N_CHANNELS(1), .DATA_WIDTH(32), .DEST_WIDTH(8), .BASE_DEST(255),
    .INITIAL_VALUES(32'd5)
  ) u1 (
    .clock(clk), .reset(s_reset), .start(s_start), .busy(s_busy), .done(s_done),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .m_tdata(s_tdata), .m_tdest(s_tdest), .m_tlast(s_tlast),
    .m_tvalid(s_tvalid), .m_tready(s_tready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dest;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    done_cnt = 0;

  function automatic word_t mk(input logic [31:0] d, input logic [7:0] t, input logic l);
    word_t w;
    w.data = d; w.dest = t; w.last = l;
    return w;
  endfunction

  // One clock: observe the default DUT mid-cycle (handshake pops the
  // scoreboard, done pulses are counted), then land 1 time unit past the edge.
  task automatic cycle();
    word_t w;
    @(negedge clk);
    if (done) done_cnt++;
    if (m_tvalid && m_tready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected got data=%0d dest=%0d last=%0d", m_tdata, m_tdest, m_tlast);
      end else begin
        w = exp_q.pop_front();
        if ({m_tdata, m_tdest, m_tlast} !== w) begin
          bad++;
          $display("FAIL sb_word got data=%0d dest=%0d last=%0d want data=%0d dest=%0d last=%0d",
                   m_tdata, m_tdest, m_tlast, w.data, w.dest, w.last);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int d0;
    reset = 1'b0; start = 1'b1; wr_en = 1'b1; wr_addr = 1'b0; wr_data = 32'd77; m_tready = 1'b1;
    cycle();
    cycle();
    total++;
    if ({busy, done, m_tvalid, m_tlast} !== 4'b0000 || m_tdata !== 32'd0 || m_tdest !== 8'd0) begin
      bad++;
      $display("FAIL reset_state got busy=%0b done=%0b valid=%0b last=%0b data=%0d dest=%0d want 0 0 0 0 0 0",
               busy, done, m_tvalid, m_tlast, m_tdata, m_tdest);
    end
    d0 = done_cnt;
    reset = 1'b1; start = 1'b0; wr_en = 1'b0;
    cycle();
    cycle();
    total++;
    if (m_tvalid !== 1'b0 || busy !== 1'b0 || done_cnt !== d0) begin
      bad++;
      $display("FAIL reset_no_pass got valid=%0b busy=%0b dones=%0d want 0 0 %0d", m_tvalid, busy, done_cnt, d0);
    end
    m_tready = 1'b0;
  endtask

  task automatic test_basic(input logic [31:0] v0, input logic [31:0] v1);
    int d0;
    d0 = done_cnt;
    exp_q.push_back(mk(v0, 8'd0, 1'b0));
    exp_q.push_back(mk(v1, 8'd1, 1'b1));
    start = 1'b1; m_tready = 1'b1;
    cycle();
    start = 1'b0;
    total++;
    if ({m_tvalid, busy, done} !== 3'b110 || m_tdata !== v0 || m_tdest !== 8'd0 || m_tlast !== 1'b0) begin
      bad++;
      $display("FAIL basic_t1 got valid=%0b busy=%0b done=%0b data=%0d dest=%0d last=%0b want 1 1 0 %0d 0 0",
               m_tvalid, busy, done, m_tdata, m_tdest, m_tlast, v0);
    end
    cycle();
    total++;
    if ({m_tvalid, busy, done} !== 3'b110 || m_tdata !== v1 || m_tdest !== 8'd1 || m_tlast !== 1'b1) begin
      bad++;
      $display("FAIL basic_t2 got valid=%0b busy=%0b done=%0b data=%0d dest=%0d last=%0b want 1 1 0 %0d 1 1",
               m_tvalid, busy, done, m_tdata, m_tdest, m_tlast, v1);
    end
    cycle();
    total++;
    if ({m_tvalid, busy, done} !== 3'b001) begin
      bad++;
      $display("FAIL basic_t3 got valid=%0b busy=%0b done=%0b want 0 0 1", m_tvalid, busy, done);
    end
    cycle();
    total++;
    if ({m_tvalid, busy, done} !== 3'b000 || exp_q.size() != 0 || done_cnt !== d0 + 1) begin
      bad++;
      $display("FAIL basic_end got valid=%0b busy=%0b done=%0b left=%0d dones=%0d want 0 0 0 0 %0d",
               m_tvalid, busy, done, exp_q.size(), done_cnt, d0 + 1);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(mk(32'd5, 8'd0, 1'b0));
    exp_q.push_back(mk(32'd32, 8'd1, 1'b1));
    m_tready = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (m_tvalid !== 1'b1 || m_tdata !== 32'd5 || m_tdest !== 8'd0 || m_tlast !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d got valid=%0b data=%0d dest=%0d last=%0b want 1 5 0 0",
                 k, m_tvalid, m_tdata, m_tdest, m_tlast);
      end
      if (k == 3) m_tready = 1'b1;
      cycle();
    end
    total++;
    if (m_tvalid !== 1'b1 || m_tdata !== 32'd32 || m_tlast !== 1'b1) begin
      bad++;
      $display("FAIL bp_second got valid=%0b data=%0d last=%0b want 1 32 1", m_tvalid, m_tdata, m_tlast);
    end
    cycle();
    cycle();
    cycle();
    total++;
    if (done_cnt !== d0 + 1 || exp_q.size() != 0 || m_tvalid !== 1'b0) begin
      bad++;
      $display("FAIL bp_done got dones=%0d left=%0d valid=%0b want %0d 0 0", done_cnt, exp_q.size(), m_tvalid, d0 + 1);
    end
  endtask

  task automatic test_write_inflight();
    exp_q.push_back(mk(32'd5, 8'd0, 1'b0));
    exp_q.push_back(mk(32'd99, 8'd1, 1'b1));
    m_tready = 1'b0; start = 1'b1;
    cycle();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 1'b1; wr_data = 32'd99;
    cycle();
    total++;
    if (m_tdata !== 32'd5) begin
      bad++;
      $display("FAIL wr_hold1 got data=%0d want 5", m_tdata);
    end
    wr_addr = 1'b0; wr_data = 32'd7;
    cycle();
    wr_en = 1'b0;
    total++;
    if (m_tdata !== 32'd5 || m_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL wr_inflight got data=%0d valid=%0b want 5 1", m_tdata, m_tvalid);
    end
    m_tready = 1'b1;
    cycle();
    total++;
    if (m_tdata !== 32'd99 || m_tdest !== 8'd1 || m_tlast !== 1'b1) begin
      bad++;
      $display("FAIL wr_later got data=%0d dest=%0d last=%0b want 99 1 1", m_tdata, m_tdest, m_tlast);
    end
    cycle();
    cycle();
    test_basic(32'd7, 32'd99);
  endtask

  task automatic test_ignored_start();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(mk(32'd7, 8'd0, 1'b0));
    exp_q.push_back(mk(32'd99, 8'd1, 1'b1));
    m_tready = 1'b0; start = 1'b1;
    cycle();
    cycle();
    total++;
    if (m_tdata !== 32'd7 || busy !== 1'b1) begin
      bad++;
      $display("FAIL ign_busy got data=%0d busy=%0b want 7 1", m_tdata, busy);
    end
    start = 1'b0; m_tready = 1'b1;
    cycle();
    cycle();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL ign_done got done=%0b want 1", done);
    end
    start = 1'b1;
    cycle();
    start = 1'b0;
    total++;
    if ({m_tvalid, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL ign_in_done got valid=%0b busy=%0b done=%0b want 0 0 0", m_tvalid, busy, done);
    end
    cycle();
    cycle();
    total++;
    if (m_tvalid !== 1'b0 || done_cnt !== d0 + 1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL ign_extra got valid=%0b dones=%0d left=%0d want 0 %0d 0", m_tvalid, done_cnt, exp_q.size(), d0 + 1);
    end
  endtask

  task automatic test_reset_midpass();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(mk(32'd7, 8'd0, 1'b0));
    start = 1'b1; m_tready = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    m_tready = 1'b0;
    total++;
    if (m_tdata !== 32'd99 || m_tlast !== 1'b1 || m_tvalid !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_held got data=%0d last=%0b valid=%0b want 99 1 1", m_tdata, m_tlast, m_tvalid);
    end
    reset = 1'b0;
    cycle();
    total++;
    if ({m_tvalid, busy, done} !== 3'b000) begin
      bad++;
      $display("FAIL rst_mid_abort got valid=%0b busy=%0b done=%0b want 0 0 0", m_tvalid, busy, done);
    end
    reset = 1'b1;
    cycle();
    cycle();
    total++;
    if (done_cnt !== d0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL rst_mid_nodone got dones=%0d left=%0d want %0d 0", done_cnt, exp_q.size(), d0);
    end
  endtask

  task automatic test_single();
    s_reset = 1'b0;
    cycle();
    total++;
    if (s_tvalid !== 1'b0 || s_tlast !== 1'b0 || s_tdest !== 8'd255 || s_tdata !== 32'd0) begin
      bad++;
      $display("FAIL single_reset got valid=%0b last=%0b dest=%0d data=%0d want 0 0 255 0",
               s_tvalid, s_tlast, s_tdest, s_tdata);
    end
    s_reset = 1'b1; s_wr_en = 1'b1; s_wr_addr = 1'b1; s_wr_data = 32'd123;
    cycle();
    s_wr_en = 1'b0; s_start = 1'b1; s_tready = 1'b1;
    cycle();
    s_start = 1'b0;
    total++;
    if ({s_tvalid, s_busy, s_tlast} !== 3'b111 || s_tdata !== 32'd5 || s_tdest !== 8'd255) begin
      bad++;
      $display("FAIL single_word got valid=%0b busy=%0b last=%0b data=%0d dest=%0d want 1 1 1 5 255",
               s_tvalid, s_busy, s_tlast, s_tdata, s_tdest);
    end
    cycle();
    total++;
    if ({s_tvalid, s_done} !== 2'b01) begin
      bad++;
      $display("FAIL single_done got valid=%0b done=%0b want 0 1", s_tvalid, s_done);
    end
    cycle();
    total++;
    if ({s_tvalid, s_done, s_busy} !== 3'b000) begin
      bad++;
      $display("FAIL single_idle got valid=%0b done=%0b busy=%0b want 0 0 0", s_tvalid, s_done, s_busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_basic(32'd5, 32'd32);
    test_backpressure();
    test_write_inflight();
    test_ignored_start();
    test_reset_midpass();
    test_basic(32'd5, 32'd32);
    test_single();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
